data_bus_arbiter: RTL and testbench

Two-requester arbiter that shares a single `DataBus` slave, typically the data memory, between two masters. Master 0 is the core data port; master 1 is the debug/DMA port. The arbiter decides ownership each cycle and routes the owner's request to the slave. It holds ownership across multi-cycle (`busy`) transactions and stalls the losing master through its `busy` line. Arbitration is round-robin, or fixed priority with a starvation guard, selected at compile time.

---
 rtl/data_bus_arbiter_pkg.sv | 37 +++
 rtl/data_bus_arbiter_if.sv | 17 +
 rtl/data_bus_arbiter_grant.sv | 50 +++++
 rtl/data_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_data_bus_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// data_bus_arbiter_pkg: shared widths, bus typedefs and owner encoding for the
// two-master data bus arbiter.
//   Addr / Data / ByteEn : DataBus field types
//   ArbOwner             : which master currently owns the shared slave
//   bus_req_t            : muxed request payload routed to the slave
package data_bus_arbiter_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = DATA_W / 8;
  localparam int unsigned BURST_W = 4;

  typedef logic [ADDR_W-1:0] Addr;
  typedef logic [DATA_W-1:0] Data;
  typedef logic [BE_W-1:0]   ByteEn;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } ArbOwner;

  typedef struct packed {
    Addr   addr;
    ByteEn be;
    logic  we;
    Data   wdata;
  } bus_req_t;

  // One-hot owner view, 00 when nobody owns the bus.
  function automatic logic [1:0] grant_onehot(input logic vld, input ArbOwner owner);
    logic [1:0] g;
    g = 2'b00;
    if (vld) g = (owner == OWNER_M0) ? 2'b01 : 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// data_bus_arbiter_if: DataBus request/response bundle.
//   master modport : drives addr/be/we/wdata, receives rdata/busy
//   slave modport  : receives addr/be/we/wdata, drives rdata/busy
interface data_bus_arbiter_if;
  import data_bus_arbiter_pkg::*;

  Addr   addr;
  ByteEn be;
  logic  we;
  Data   wdata;
  Data   rdata;
  logic  busy;

  modport master (output addr, be, we, wdata, input rdata, busy);
  modport slave  (input addr, be, we, wdata, output rdata, busy);

endinterface

// File: rtl/data_bus_arbiter_grant.sv
// data_bus_arbiter_grant: pure combinational owner selection.
// Build option: DATA_BUS_ARBITER_RR_EN selects round-robin (uses last_i);
// otherwise fixed priority to master 0 with a MAX_BURST starvation guard.
//   lock_i / lock_owner_i : held ownership across a busy transaction
//   last_i                : last completing master (round-robin only)
//   burst_cnt_i           : consecutive master-0 completions while master 1 waits
//   req0_i / req1_i       : request lines
//   owner_vld_c_o / owner_c_o : selected owner, combinational
module data_bus_arbiter_grant
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               lock_i,
  input  ArbOwner            lock_owner_i,
`ifdef DATA_BUS_ARBITER_RR_EN
  input  ArbOwner            last_i,
`else
  input  logic [BURST_W-1:0] burst_cnt_i,
`endif
  input  logic               req0_i,
  input  logic               req1_i,
  output logic               owner_vld_c_o,
  output ArbOwner            owner_c_o
);

  // Lock beats contention; contention resolves by mode; a lone requester wins.
  always_comb begin
    owner_vld_c_o = 1'b0;
    owner_c_o     = OWNER_M0;
    if (lock_i) begin
      owner_vld_c_o = 1'b1;
      owner_c_o     = lock_owner_i;
    end else if (req0_i && req1_i) begin
      owner_vld_c_o = 1'b1;
`ifdef DATA_BUS_ARBITER_RR_EN
      owner_c_o     = (last_i == OWNER_M0) ? OWNER_M1 : OWNER_M0;
`else
      owner_c_o     = (burst_cnt_i >= BURST_W'(MAX_BURST)) ? OWNER_M1 : OWNER_M0;
`endif
    end else if (req0_i) begin
      owner_vld_c_o = 1'b1;
      owner_c_o     = OWNER_M0;
    end else if (req1_i) begin
      owner_vld_c_o = 1'b1;
      owner_c_o     = OWNER_M1;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: shares one DataBus slave between master 0 (core data port)
// and master 1 (debug/DMA). Ownership is held across busy transactions and the
// losing requester is stalled through its busy line.
// Build option: DATA_BUS_ARBITER_RR_EN -> round-robin; default -> fixed
// priority to master 0 with MAX_BURST (1..15) starvation guard for master 1.
//   i_clock, i_reset_n : clock, async active-low reset
//   i_req0, i_req1     : per-master request valid
//   m0, m1             : master ports (DataBus slave side)
//   mem                : shared slave port (DataBus master side)
//   o_grant            : one-hot current owner (debug/coverage), combinational
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_req0,
  input  logic                      i_req1,
  data_bus_arbiter_if.slave         m0,
  data_bus_arbiter_if.slave         m1,
  data_bus_arbiter_if.master        mem,
  output logic [1:0]                o_grant
);

  logic     lock_q, lock_d;
  ArbOwner  lock_owner_q, lock_owner_d;
  logic     owner_vld;
  ArbOwner  owner;
  logic     done;
  bus_req_t mem_req;

`ifdef DATA_BUS_ARBITER_RR_EN
  // Completion history only steers round-robin; fixed priority uses burst_cnt instead.
  ArbOwner last_q, last_d;
`else
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

  data_bus_arbiter_grant #(.MAX_BURST(MAX_BURST)) u_grant (
    .lock_i        (lock_q),
    .lock_owner_i  (lock_owner_q),
`ifdef DATA_BUS_ARBITER_RR_EN
    .last_i        (last_q),
`else
    .burst_cnt_i   (burst_cnt_q),
`endif
    .req0_i        (i_req0),
    .req1_i        (i_req1),
    .owner_vld_c_o (owner_vld),
    .owner_c_o     (owner)
  );

  assign done    = owner_vld & ~mem.busy;
  assign o_grant = grant_onehot(owner_vld, owner);

  // Owner's payload to the slave; write strobe gated by the owner's live req.
  always_comb begin
    mem_req = '0;
    if (owner_vld) begin
      if (owner == OWNER_M0) begin
        mem_req.addr  = m0.addr;
        mem_req.be    = m0.be;
        mem_req.we    = m0.we & i_req0;
        mem_req.wdata = m0.wdata;
      end else begin
        mem_req.addr  = m1.addr;
        mem_req.be    = m1.be;
        mem_req.we    = m1.we & i_req1;
        mem_req.wdata = m1.wdata;
      end
    end
  end

  assign mem.addr  = mem_req.addr;
  assign mem.be    = mem_req.be;
  assign mem.we    = mem_req.we;
  assign mem.wdata = mem_req.wdata;

  assign m0.rdata = mem.rdata;
  assign m1.rdata = mem.rdata;

  // A non-owner stalls exactly when it is requesting.
  assign m0.busy = (owner_vld && owner == OWNER_M0) ? mem.busy : i_req0;
  assign m1.busy = (owner_vld && owner == OWNER_M1) ? mem.busy : i_req1;

  // Lock is re-evaluated every cycle; it survives only while the slave stays busy.
  always_comb begin
    lock_d       = 1'b0;
    lock_owner_d = lock_owner_q;
    if (owner_vld && mem.busy) begin
      lock_d       = 1'b1;
      lock_owner_d = owner;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_M0;
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
    end
  end

`ifdef DATA_BUS_ARBITER_RR_EN
  always_comb begin
    last_d = last_q;
    if (done) last_d = owner;
  end

  // Reset to M1 so master 0 wins the first contention.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) last_q <= OWNER_M1;
    else            last_q <= last_d;
  end
`else
  // Counts master-0 completions while master 1 waits; saturates at all-ones.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!i_req1 || (done && owner == OWNER_M1)) begin
      burst_cnt_d = '0;
    end else if (done && owner == OWNER_M0 && burst_cnt_q != '1) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) burst_cnt_q <= '0;
    else            burst_cnt_q <= burst_cnt_d;
  end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed scenarios plus randomized traffic for
// data_bus_arbiter, checked against a cycle-level ownership model.
// Follows DATA_BUS_ARBITER_RR_EN in the same way as the design.
module tb_data_bus_arbiter;
  import data_bus_arbiter_pkg::*;

  localparam int unsigned MAXB = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0  = 1'b0;
  logic       req1  = 1'b0;
  logic [1:0] o_grant;

  data_bus_arbiter_if m0_if ();
  data_bus_arbiter_if m1_if ();
  data_bus_arbiter_if mem_if ();

  int checks   = 0;
  int failures = 0;

  // Model state: holder of an unfinished transaction (-1 none), last completer,
  // and master-0 completions in a row while master 1 has been waiting.
  int hold_m   = -1;
  int last_m   = 1;
  int streak_m = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(.MAX_BURST(MAXB)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_req0    (req0),
    .i_req1    (req1),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem       (mem_if),
    .o_grant   (o_grant)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_owner();
    if (hold_m >= 0) return hold_m;
    if (req0 && req1) begin
`ifdef DATA_BUS_ARBITER_RR_EN
      return 1 - last_m;
`else
      return (streak_m >= int'(MAXB)) ? 1 : 0;
`endif
    end
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    hold_m   = -1;
    last_m   = 1;
    streak_m = 0;
  endtask

  task automatic check_outputs();
    int         own;
    logic [1:0] g;
    Addr        ea;
    ByteEn      eb;
    logic       ewe;
    Data        ew;
    logic       eb0, eb1;
    own = exp_owner();
    g   = (own < 0) ? 2'b00 : ((own == 0) ? 2'b01 : 2'b10);
    ea = '0; eb = '0; ewe = 1'b0; ew = '0;
    if (own == 0) begin
      ea = m0_if.addr; eb = m0_if.be; ewe = m0_if.we & req0; ew = m0_if.wdata;
    end else if (own == 1) begin
      ea = m1_if.addr; eb = m1_if.be; ewe = m1_if.we & req1; ew = m1_if.wdata;
    end
    eb0 = (own == 0) ? mem_if.busy : req0;
    eb1 = (own == 1) ? mem_if.busy : req1;
    check("grant",    64'(o_grant),      64'(g));
    check("mem_addr", 64'(mem_if.addr),  64'(ea));
    check("mem_be",   64'(mem_if.be),    64'(eb));
    check("mem_we",   64'(mem_if.we),    64'(ewe));
    check("mem_wdat", 64'(mem_if.wdata), 64'(ew));
    check("m0_busy",  64'(m0_if.busy),   64'(eb0));
    check("m1_busy",  64'(m1_if.busy),   64'(eb1));
    check("m0_rdata", 64'(m0_if.rdata),  64'(mem_if.rdata));
    check("m1_rdata", 64'(m1_if.rdata),  64'(mem_if.rdata));
  endtask

  task automatic model_update();
    int   own;
    logic fin;
    own = exp_owner();
    fin = (own >= 0) && !mem_if.busy;
    if (own >= 0 && mem_if.busy) begin
      hold_m = own;
    end else begin
      hold_m = -1;
      if (own >= 0) last_m = own;
    end
    if (!req1 || (fin && own == 1)) streak_m = 0;
    else if (fin && own == 0 && streak_m < 15) streak_m++;
  endtask

  task automatic rand_payload();
    m0_if.addr   = $urandom;
    m0_if.be     = 4'($urandom);
    m0_if.we     = 1'($urandom);
    m0_if.wdata  = $urandom;
    m1_if.addr   = $urandom;
    m1_if.be     = 4'($urandom);
    m1_if.we     = 1'($urandom);
    m1_if.wdata  = $urandom;
    mem_if.rdata = $urandom;
  endtask

  // One clock: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic cycle(input logic r0, input logic r1, input logic b, input int exp_g);
    @(negedge clk);
    req0        = r0;
    req1        = r1;
    mem_if.busy = b;
    #1;
    check_outputs();
    if (exp_g >= 0) check("dir_grant", 64'(o_grant), 64'(exp_g));
    @(posedge clk);
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    req0        = 1'b0;
    req1        = 1'b0;
    mem_if.busy = 1'b0;
    model_reset();
    #1;
    check("rst_grant", 64'(o_grant),      64'(0));
    check("rst_addr",  64'(mem_if.addr),  64'(0));
    check("rst_be",    64'(mem_if.be),    64'(0));
    check("rst_we",    64'(mem_if.we),    64'(0));
    check("rst_wdata", 64'(mem_if.wdata), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int seq_g[6];
`ifdef DATA_BUS_ARBITER_RR_EN
    seq_g = '{1, 2, 1, 2, 1, 2};
`else
    seq_g = '{1, 1, 2, 1, 1, 2};
`endif
    mem_if.busy = 1'b0;
    rand_payload();
    do_reset();

    // Solo master 0 write passes straight through.
    m0_if.addr  = 32'h0000_0100;
    m0_if.be    = 4'hF;
    m0_if.we    = 1'b1;
    m0_if.wdata = 32'hDEAD_BEEF;
    cycle(1'b1, 1'b0, 1'b0, 1);

    // Continuous contention with single-cycle transactions.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rand_payload();
      m0_if.we = 1'b0;
      m1_if.we = 1'b0;
      cycle(1'b1, 1'b1, 1'b0, seq_g[i]);
    end

    // Master 1 holds the bus through three busy cycles plus completion.
    do_reset();
    cycle(1'b0, 1'b1, 1'b1, 2);
    cycle(1'b1, 1'b1, 1'b1, 2);
    cycle(1'b1, 1'b1, 1'b1, 2);
    cycle(1'b1, 1'b1, 1'b0, 2);
    cycle(1'b1, 1'b1, 1'b0, 1);

    // Reset while locked, then master 0 wins first contention.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1);
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 1);

    // Owner drops req while the slave is still busy.
    do_reset();
    rand_payload();
    m0_if.we = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 1);
    cycle(1'b0, 1'b1, 1'b1, 1);
    cycle(1'b0, 1'b1, 1'b0, 1);
    cycle(1'b0, 1'b1, 1'b0, 2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      rand_payload();
      cycle(($urandom_range(3) != 0), ($urandom_range(3) != 0), ($urandom_range(2) == 0), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
